// File: rtl/fsm1_din_conditioner.sv
// Din conditioner for the Ch-8 sequence detectors: 2-flop synchroniser, debounce FSM,
// one pulse per accepted rising edge, saturating pulse count. FSM1_DIN_GLITCH_COUNT_EN adds Glitch_count.
module fsm1_din_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Raw_in,
  input  logic             Enable,
  output logic             Pulse_out,
  output logic             Level_out,
  output logic [CNT_W-1:0] Pulse_count
`ifdef FSM1_DIN_GLITCH_COUNT_EN
  ,
  output logic [CNT_W-1:0] Glitch_count
`endif
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0]    CNT_ONE = DW'(1);
  localparam logic [CNT_W-1:0] PC_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE_LOW,
    ARMING_HIGH,
    STABLE_HIGH,
    ARMING_LOW
  } state_t;

  state_t          state, state_d;
  logic            s1, s;
  logic [DW-1:0]   cnt, cnt_d;
  logic            pulse_d, level_d, glitch, done;

  // The sample that triggers entry into an arming state counts as the first stable sample.
  always_comb begin
    done = (({{(32-DW){1'b0}}, cnt} + 32'd2) >= DEBOUNCE_CYCLES);
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    glitch  = 1'b0;
    if (!Enable) begin
      state_d = IDLE_LOW;
      cnt_d   = '0;
    end else begin
      case (state)
        IDLE_LOW: begin
          if (s) begin
            state_d = ARMING_HIGH;
            cnt_d   = '0;
          end
        end
        ARMING_HIGH: begin
          if (!s) begin
            state_d = IDLE_LOW;
            cnt_d   = '0;
            glitch  = 1'b1;
          end else if (done) begin
            state_d = STABLE_HIGH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + CNT_ONE;
          end
        end
        STABLE_HIGH: begin
          if (!s) begin
            state_d = ARMING_LOW;
            cnt_d   = '0;
          end
        end
        ARMING_LOW: begin
          if (s) begin
            state_d = STABLE_HIGH;
            cnt_d   = '0;
            glitch  = 1'b1;
          end else if (done) begin
            state_d = IDLE_LOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end
      endcase
    end
    pulse_d = (state == ARMING_HIGH) && (state_d == STABLE_HIGH);
    level_d = (state_d == STABLE_HIGH) || (state_d == ARMING_LOW);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      s1          <= 1'b0;
      s           <= 1'b0;
      state       <= IDLE_LOW;
      cnt         <= '0;
      Pulse_out   <= 1'b0;
      Level_out   <= 1'b0;
      Pulse_count <= '0;
    end else begin
      s1        <= Raw_in;
      s         <= s1;
      state     <= state_d;
      cnt       <= cnt_d;
      Pulse_out <= pulse_d;
      Level_out <= level_d;
      if (pulse_d && (Pulse_count != '1)) begin
        Pulse_count <= Pulse_count + PC_ONE;
      end
    end
  end

`ifdef FSM1_DIN_GLITCH_COUNT_EN
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Glitch_count <= '0;
    end else if (glitch && (Glitch_count != '1)) begin
      Glitch_count <= Glitch_count + PC_ONE;
    end
  end
`else
  logic unused_glitch;
  always_comb unused_glitch = glitch;
`endif

endmodule

// File: tb/tb_fsm1_din_conditioner.sv
// Self-checking bench for fsm1_din_conditioner: per-cycle scoreboard against a behavioural
// model, a segment table for clean presses/enable, and directed latency/reset/glitch sequences.
module tb_fsm1_din_conditioner;

  localparam int D = 4;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Raw_in = 1'b0;
  logic       Enable = 1'b0;
  logic       Pulse_out, Level_out, Pulse_out2, Level_out2;
  logic [7:0] Pulse_count;
  logic [1:0] Pulse_count2;
`ifdef FSM1_DIN_GLITCH_COUNT_EN
  logic [7:0] Glitch_count;
  logic [1:0] Glitch_count2;
`endif

  always #5 Clock = ~Clock;

  fsm1_din_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
    .Clock(Clock), .Reset(Reset), .Raw_in(Raw_in), .Enable(Enable),
    .Pulse_out(Pulse_out), .Level_out(Level_out), .Pulse_count(Pulse_count)
`ifdef FSM1_DIN_GLITCH_COUNT_EN
    , .Glitch_count(Glitch_count)
`endif
  );

  fsm1_din_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(2)) dut2 (
    .Clock(Clock), .Reset(Reset), .Raw_in(Raw_in), .Enable(Enable),
    .Pulse_out(Pulse_out2), .Level_out(Level_out2), .Pulse_count(Pulse_count2)
`ifdef FSM1_DIN_GLITCH_COUNT_EN
    , .Glitch_count(Glitch_count2)
`endif
  );

  typedef struct {
    logic pulse;
    logic level;
    int   cnt;
    int   cnt2;
    int   glitch;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  // Behavioural reference: debounced level plus a run length of samples that disagree with it.
  logic m_s1, m_s, m_lvl, m_arming, m_pulse;
  int   m_run, m_cnt, m_cnt2, m_glitch;

  task automatic model_step(input logic r, input logic e, input logic rst);
    logic old_s;
    if (rst) begin
      m_s1 = 0; m_s = 0; m_lvl = 0; m_arming = 0; m_pulse = 0;
      m_run = 0; m_cnt = 0; m_cnt2 = 0; m_glitch = 0;
      return;
    end
    old_s   = m_s;
    m_s     = m_s1;
    m_s1    = r;
    m_pulse = 0;
    if (!e) begin
      m_lvl = 0; m_arming = 0; m_run = 0;
    end else if (!m_arming) begin
      if (old_s != m_lvl) begin
        m_arming = 1; m_run = 1;
      end
    end else if (old_s == m_lvl) begin
      m_arming = 0; m_run = 0;
      if (m_glitch < 255) m_glitch++;
    end else begin
      m_run++;
      if (m_run >= D) begin
        m_arming = 0; m_lvl = old_s; m_run = 0;
        if (old_s) begin
          m_pulse = 1;
          if (m_cnt < 255) m_cnt++;
          if (m_cnt2 < 3) m_cnt2++;
        end
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // One clock: drive at negedge, model on posedge, compare at next negedge.
  task automatic tick(input logic r, input logic e, input logic rst);
    exp_t x;
    Raw_in = r; Enable = e; Reset = rst;
    @(posedge Clock);
    model_step(r, e, rst);
    x.pulse = m_pulse; x.level = m_lvl; x.cnt = m_cnt; x.cnt2 = m_cnt2; x.glitch = m_glitch;
    sb.push_back(x);
    @(negedge Clock);
    cyc++;
    x = sb.pop_front();
    chk("pulse", int'(Pulse_out), int'(x.pulse));
    chk("level", int'(Level_out), int'(x.level));
    chk("count", int'(Pulse_count), x.cnt);
    chk("pulse_w2", int'(Pulse_out2), int'(x.pulse));
    chk("count_w2", int'(Pulse_count2), x.cnt2);
`ifdef FSM1_DIN_GLITCH_COUNT_EN
    chk("glitch", int'(Glitch_count), x.glitch);
`endif
  endtask

  typedef struct {
    logic raw;
    logic en;
    int   cycles;
    int   exp_pulses;
    logic exp_level;
  } seg_t;

  seg_t tbl[11];
  int   npulse;
  int   nlev;

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 10, 1, 1'b1};
    tbl[1]  = '{1'b0, 1'b1, 10, 0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 10, 1, 1'b1};
    tbl[3]  = '{1'b0, 1'b1, 10, 0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 10, 1, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 10, 0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 20, 0, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 10, 1, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 10, 0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 10, 1, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 10, 0, 1'b0};

    @(negedge Clock);

    // Reset state and latency: pulse only after edge D+2 counted from first Raw_in=1 sample.
    tick(1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b1);
    chk("rst_pulse", int'(Pulse_out), 0);
    chk("rst_level", int'(Level_out), 0);
    chk("rst_count", int'(Pulse_count), 0);
    for (int i = 1; i <= D + 4; i++) begin
      tick(1'b1, 1'b1, 1'b0);
      chk("lat_pulse", int'(Pulse_out), (i == D + 2) ? 1 : 0);
      chk("lat_level", int'(Level_out), (i >= D + 2) ? 1 : 0);
    end
    chk("lat_count", int'(Pulse_count), 1);

    // Bouncing input: no pulse while toggling, exactly one after it settles high.
    tick(1'b0, 1'b1, 1'b1);
    npulse = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1'((i + 1) % 2), 1'b1, 1'b0);
      npulse += int'(Pulse_out);
    end
    chk("bounce_pulses", npulse, 0);
    for (int i = 0; i < 12; i++) begin
      tick(1'b1, 1'b1, 1'b0);
      npulse += int'(Pulse_out);
    end
    chk("settle_pulses", npulse, 1);
    chk("settle_count", int'(Pulse_count), 1);
`ifdef FSM1_DIN_GLITCH_COUNT_EN
    chk("glitch_seen", int'(Glitch_count >= 8'd1), 1);
`endif

    // Clean presses, releases and Enable gating from the table.
    tick(1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 11; k++) begin
      npulse = 0;
      nlev = 0;
      for (int i = 0; i < tbl[k].cycles; i++) begin
        tick(tbl[k].raw, tbl[k].en, 1'b0);
        npulse += int'(Pulse_out);
        nlev += int'(Level_out);
      end
      chk($sformatf("seg%0d_pulses", k), npulse, tbl[k].exp_pulses);
      chk($sformatf("seg%0d_level", k), int'(Level_out), int'(tbl[k].exp_level));
      if (!tbl[k].en) chk($sformatf("seg%0d_level_any", k), nlev, 0);
    end
    chk("final_count", int'(Pulse_count), 5);
    chk("sat_count_w2", int'(Pulse_count2), 3);

    // Reset mid-arming: no pulse, then a fresh sequence with normal latency from release.
    tick(1'b0, 1'b1, 1'b1);
    npulse = 0;
    for (int i = 1; i <= 3; i++) begin
      tick(1'b1, 1'b1, 1'b0);
      npulse += int'(Pulse_out);
    end
    tick(1'b1, 1'b1, 1'b1);
    chk("midrst_pulse", int'(Pulse_out), 0);
    chk("midrst_level", int'(Level_out), 0);
    chk("midrst_count", int'(Pulse_count), 0);
    for (int i = 1; i <= D + 4; i++) begin
      tick(1'b1, 1'b1, 1'b0);
      npulse += int'(Pulse_out);
      chk("rearm_pulse", int'(Pulse_out), (i == D + 2) ? 1 : 0);
    end
    chk("rearm_total", npulse, 1);
    chk("rearm_count", int'(Pulse_count), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
